// File: rtl/operand_shift_host_pkg.sv
// Shared types and constants for the serial operand host.
package operand_shift_host_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS_HI = 2'd1,
    PASS_LO = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int NUM_LANES     = 3;
  localparam int LANE_A        = 0;
  localparam int LANE_B        = 1;
  localparam int LANE_C        = 2;

endpackage

// File: rtl/operand_shift_host_rotator.sv
// One operand lane: parallel-loadable rotate-left register whose MSB drives the serial line.
module serial_rotator
  import operand_shift_host_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rot_en,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  // Clear wins so the lane goes quiet on the same edge the last result byte is captured.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_rot_en) begin
      r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/operand_shift_host.sv
// Host-side initiator: shifts three operands MSB-first into the receiver, then reads the
// 32-bit result back as two byte-pair passes selected by o_sel_lo.
//
// state   | meaning
// IDLE    | ready for operands, lanes quiet
// PASS_HI | first full rotation, then capture result bytes [15:8]/[31:24]
// PASS_LO | second full rotation, then capture result bytes [7:0]/[23:16]
// DONE    | result held until the consumer accepts it
module operand_shift_host
  import operand_shift_host_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int RESULT_LATENCY = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  input  logic [WIDTH-1:0] i_in_c,
  output logic [2:0]       o_ser,
  output logic             o_sel_lo,
  input  logic [7:0]       i_res_b0,
  input  logic [7:0]       i_res_b1,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_result
);

  localparam int CNT_W = $clog2(3 * WIDTH);
  // Counter holds k-1 before edge k, so each capture fires one count early.
  localparam logic [CNT_W-1:0] HI_CAP = CNT_W'(WIDTH + RESULT_LATENCY);
  localparam logic [CNT_W-1:0] LO_CAP = CNT_W'(2 * WIDTH + RESULT_LATENCY);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_sel_lo;
  logic             r_out_valid;
  logic [31:0]      r_out_result;

  logic             w_accept;
  logic             w_rot_en;
  logic             w_clear;
  logic [WIDTH-1:0] w_operand [NUM_LANES];

  assign w_accept = i_in_valid && r_in_ready;
  assign w_rot_en = (r_state == PASS_HI) || (r_state == PASS_LO);
  assign w_clear  = (r_state == PASS_LO) && (r_cnt == LO_CAP);

  assign w_operand[LANE_A] = i_in_a;
  assign w_operand[LANE_B] = i_in_b;
  assign w_operand[LANE_C] = i_in_c;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    serial_rotator #(.WIDTH(WIDTH)) u_rot (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (w_clear),
      .i_load   (w_accept),
      .i_data   (w_operand[g]),
      .i_rot_en (w_rot_en),
      .o_msb    (o_ser[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_in_ready   <= 1'b1;
      r_sel_lo     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready   <= 1'b0;
            r_cnt        <= '0;
            r_out_result <= '0;
            r_state      <= PASS_HI;
          end
        end
        PASS_HI: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == HI_CAP) begin
            r_out_result[15:8]  <= i_res_b0;
            r_out_result[31:24] <= i_res_b1;
            r_sel_lo            <= 1'b1;
            r_state             <= PASS_LO;
          end
        end
        PASS_LO: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LO_CAP) begin
            r_out_result[7:0]   <= i_res_b0;
            r_out_result[23:16] <= i_res_b1;
            r_sel_lo            <= 1'b0;
            r_out_valid         <= 1'b1;
            r_state             <= DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_sel_lo     = r_sel_lo;
  assign o_out_valid  = r_out_valid;
  assign o_out_result = r_out_result;

endmodule

// File: doc/operand_shift_host.md
# operand_shift_host

Host-side initiator for the size-exploration serial operand interface. Accepts parallel operand words over a valid/ready handshake, drives them bit-serially MSB-first onto the three operand lanes (chip `ui_in[2:0]`), and reads the 32-bit result back. The read uses the byte-select line (chip `ui_in[7]`) and the two result byte buses (chip `uo_out`, `uio_out`). It sits in the FPGA/bench harness directly in front of the exploration top level, whose receive shift registers run every clock with no enable.

## Interface
- `WIDTH`, 32, operand word length in bits; must equal the receiver shift-register length.
- `RESULT_LATENCY`, 0, register stages between the receiver shift registers and the result mux. 0 for MULT/ADDER/MANDELBROT. Legal range 0..WIDTH-1.

- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operand words valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`, `in_b`, `in_c`  in  WIDTH each  operands for lanes 0, 1, 2.
- `ser`  out  3  serial lanes to `ui_in[2:0]`; bit i carries operand i.
- `sel_lo`  out  1  to `ui_in[7]`. 1 selects result bytes [7:0]/[23:16]; 0 selects [15:8]/[31:24].
- `res_b0`  in  8  from `uo_out`.
- `res_b1`  in  8  from `uio_out`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  32  assembled result.

## Operation
- States: IDLE, PASS_HI, PASS_LO, DONE.
- **IDLE**
  - `in_ready` = 1, `ser` = 0, `sel_lo` = 0.
  - On `in_valid && in_ready`: load three WIDTH-bit rotate registers with `in_a`/`in_b`/`in_c`, clear the cycle counter, go to PASS_HI.
- **Rotation (PASS_HI and PASS_LO)**
  - Each lane's `ser` bit is the MSB of its rotate register.
  - Every cycle each register rotates left by 1, old MSB into LSB.
  - The receiver therefore holds the exact operand words after every WIDTH-th edge.
- **PASS_HI**
  - `sel_lo` = 0.
  - At edge WIDTH+1+RESULT_LATENCY after acceptance: capture `res_b0` into `out_result[15:8]` and `res_b1` into `out_result[31:24]`, set `sel_lo` = 1, go to PASS_LO.
- **PASS_LO**
  - At edge 2·WIDTH+1+RESULT_LATENCY after acceptance: capture `res_b0` into `out_result[7:0]` and `res_b1` into `out_result[23:16]`.
  - Same edge: `ser` to 0, `sel_lo` to 0, `out_valid` to 1, go to DONE.
- **DONE**
  - `out_valid` and `out_result` held until `out_ready`; then go to IDLE.
  - `in_ready` stays 0 in the handshake cycle; a new accept happens no earlier than the following cycle.
- The counter counts acceptance-relative edges, width `$clog2(3·WIDTH)`; it never wraps within a transaction.
- `out_result` bits not yet captured read 0 (cleared on accept).

## Timing
- Reset (async assert, sync deassert at the next `clk` edge): state IDLE, `in_ready` = 1, `ser` = 0, `sel_lo` = 0, `out_valid` = 0, `out_result` = 0, rotate registers 0.
- Reset asserted mid-transaction aborts immediately with no partial result. The downstream receiver is reset separately by the same `rst_n`.
- `ser` bit k = operand bit WIDTH-1-k during cycle k+1 after acceptance.
- Latency from accept edge to `out_valid` high: 2·WIDTH+1+RESULT_LATENCY cycles (65 for defaults).
- Throughput: one transaction per 2·WIDTH+3+RESULT_LATENCY cycles with `out_ready` held high.
- `in_valid` while busy is ignored; it is not buffered.
- `sel_lo` changes only on the PASS_HI capture edge and the PASS_LO exit edge.

## Structure
- Package `operand_shift_host_pkg`: state enum (IDLE, PASS_HI, PASS_LO, DONE), `DEFAULT_WIDTH` = 32, lane index constants `LANE_A` = 0, `LANE_B` = 1, `LANE_C` = 2.
- Sub-module `serial_rotator`, instanced 3×:
  - Parallel load.
  - Rotate-left enable.
  - Clear.
  - MSB output.
- Top holds the FSM, counter, capture registers and handshakes.

## Test plan
Bench instantiates the exploration top level behind this block.
- **ADDER, WIDTH = 32, RESULT_LATENCY = 0, INPUT_WIDTH = 8**
  - `in_a` = 0x000000FF, `in_b` = 0x00000001 → `out_result` = 0x00000100, `out_valid` exactly 65 cycles after accept.
- **MULT, INPUT_WIDTH = 8**
  - `in_a` = 0xFF, `in_b` = 0xFF → 0x0000FE01.
  - Back-to-back with `out_ready` = 1: 0x03 × 0x05 → 0x0000000F; second accept exactly 1 cycle after the first result handshake.
- **Serial waveform**
  - `in_a` = 0x80000001 → `ser[0]` high in cycles 1 and 32 after accept, and again in cycles 33 and 64 (rotation).
  - `sel_lo` rises at edge 33, returns to 0 at edge 65.
- **Backpressure**
  - Hold `out_ready` = 0 for 10 cycles → `out_valid` and `out_result` stable; `in_ready` = 0; `in_valid` pulses ignored.
- **Reset mid-PASS_LO**
  - Assert `rst_n` = 0 at cycle 40 → all outputs at reset values without waiting for a clock edge.
  - Next transaction returns a correct result.
